// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared button index map and difficulty encodings used by the
//             button conditioner and the top-level wrapper.
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Bit positions of the board push-buttons inside btn_raw / btn_level / btn_press
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  // Lowest button count that still covers every mapped button
  localparam int BTN_MAP_COUNT = 5;

  // Difficulty encodings driven onto the processor difficulty_in bus
  localparam logic [31:0] DIFF_EASY = 32'd1;
  localparam logic [31:0] DIFF_MED  = 32'd2;
  localparam logic [31:0] DIFF_HARD = 32'd3;

  // Next difficulty from this cycle's press pulses; L beats C beats R,
  // and a locked register keeps its current value.
  function automatic logic [31:0] next_difficulty(
    input logic [31:0] cur,
    input logic        lock,
    input logic        press_l,
    input logic        press_c,
    input logic        press_r
  );
    logic [31:0] nxt;
    nxt = cur;
    if (!lock) begin
      if (press_l) begin
        nxt = DIFF_EASY;
      end else if (press_c) begin
        nxt = DIFF_MED;
      end else if (press_r) begin
        nxt = DIFF_HARD;
      end
    end
    return nxt;
  endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : One push-button channel: two-flop synchronizer, counter-based
//             debounce of both press and release, and a registered one-cycle
//             pulse on each debounced rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  // The counter must reach DEBOUNCE_CYCLES-1 without wrapping
  generate
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
      $error("debounce_channel: CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             press_q;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Pulse for one cycle, the cycle after the debounced level rises
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Conditions the five board push-buttons (sync, debounce, press
//             pulse) and holds the lockable difficulty register fed to the CPU.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import game_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int DIFF_RESET      = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               difficulty_lock,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [31:0]        difficulty,
  output logic               difficulty_changed
);

  // The difficulty logic addresses buttons by their fixed bit positions
  generate
    if (NUM_BTN < BTN_MAP_COUNT) begin : g_bad_num_btn
      $error("button_conditioner: NUM_BTN must cover the U/D/L/R/C map");
    end
  endgenerate

  localparam logic [31:0] c_DIFF_RESET = 32'(DIFF_RESET);

  // One independent conditioning channel per button
  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_chan (
        .clock (clock),
        .reset (reset),
        .raw   (btn_raw[i]),
        .level (btn_level[i]),
        .press (btn_press[i])
      );
    end
  endgenerate

  logic [31:0] diff_q;
  logic [31:0] diff_d;
  logic        changed_q;
  logic        changed_d;

  // Select the next difficulty from this cycle's press pulses
  always_comb begin
    diff_d    = next_difficulty(diff_q, difficulty_lock,
                                btn_press[BTN_L], btn_press[BTN_C], btn_press[BTN_R]);
    changed_d = (diff_d != diff_q);
  end

  // Difficulty register and its change pulse update together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      diff_q    <= c_DIFF_RESET;
      changed_q <= 1'b0;
    end else begin
      diff_q    <= diff_d;
      changed_q <= changed_d;
    end
  end

  assign difficulty         = diff_q;
  assign difficulty_changed = changed_q;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Scoreboard bench for button_conditioner with a window-based
//             reference model of sync/debounce/press/difficulty.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int D  = 4;

  logic          clock;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic          difficulty_lock;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [31:0]   difficulty;
  logic          difficulty_changed;

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .DIFF_RESET      (1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .btn_raw            (btn_raw),
    .difficulty_lock    (difficulty_lock),
    .btn_level          (btn_level),
    .btn_press          (btn_press),
    .difficulty         (difficulty),
    .difficulty_changed (difficulty_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [31:0]   diff;
    logic          changed;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   running  = 1'b0;

  // Reference model state: raw history feeding the synchronizer delay,
  // window of the last D synchronized samples, accepted level, pending rise.
  bit          rh  [NB][$];
  bit          win [NB][$];
  bit [NB-1:0] m_level;
  bit [NB-1:0] m_rose;
  bit [NB-1:0] m_press;
  logic [31:0] m_diff;
  bit          m_changed;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      rh[i].delete();
      rh[i].push_back(1'b0);
      rh[i].push_back(1'b0);
      win[i].delete();
    end
    m_level   = '0;
    m_rose    = '0;
    m_press   = '0;
    m_diff    = 32'd1;
    m_changed = 1'b0;
  endtask

  // Advance the model by one active edge and queue the expected outputs
  task automatic model_step(input logic [NB-1:0] raw, input logic lk, input logic rst);
    exp_t        e;
    bit [NB-1:0] new_press;
    logic [31:0] nd;
    if (rst) begin
      model_reset();
    end else begin
      nd = m_diff;
      if (!lk) begin
        if (m_press[2])      nd = 32'd1;
        else if (m_press[4]) nd = 32'd2;
        else if (m_press[3]) nd = 32'd3;
      end
      m_changed = (nd != m_diff);
      m_diff    = nd;
      for (int i = 0; i < NB; i++) begin
        bit s;
        bit all_diff;
        s = rh[i].pop_front();
        rh[i].push_back(raw[i]);
        win[i].push_back(s);
        if (win[i].size() > D) void'(win[i].pop_front());
        all_diff = (win[i].size() == D);
        foreach (win[i][k]) if (win[i][k] == m_level[i]) all_diff = 1'b0;
        new_press[i] = m_rose[i];
        m_rose[i]    = all_diff && !m_level[i];
        if (all_diff) m_level[i] = !m_level[i];
      end
      m_press = new_press;
    end
    e.level   = m_level;
    e.press   = m_press;
    e.diff    = m_diff;
    e.changed = m_changed;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; a fresh reset is raised between edges and its
  // effect on the outputs is checked before the next edge arrives.
  task automatic drive(input logic [NB-1:0] raw, input logic lk, input bit do_rst);
    @(negedge clock);
    cyc++;
    btn_raw         = raw;
    difficulty_lock = lk;
    if (do_rst && !reset) begin
      #2;
      reset = 1'b1;
      #1;
      chk("async_level",   32'(btn_level), 32'd0);
      chk("async_press",   32'(btn_press), 32'd0);
      chk("async_diff",    difficulty, 32'd1);
      chk("async_changed", 32'(difficulty_changed), 32'd0);
    end else if (!do_rst) begin
      reset = 1'b0;
    end
    model_step(raw, lk, do_rst);
    running = 1'b1;
  endtask

  task automatic run(input logic [NB-1:0] raw, input logic lk, input int n);
    for (int k = 0; k < n; k++) drive(raw, lk, 1'b0);
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (running) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty cyc=%0d got=none exp=entry", cyc);
        end else begin
          e = sb.pop_front();
          chk("level",   32'(btn_level), 32'(e.level));
          chk("press",   32'(btn_press), 32'(e.press));
          chk("diff",    difficulty, e.diff);
          chk("changed", 32'(difficulty_changed), 32'(e.changed));
        end
      end
    end
  end

  localparam logic [NB-1:0] B_L  = 5'b00100;
  localparam logic [NB-1:0] B_R  = 5'b01000;
  localparam logic [NB-1:0] B_C  = 5'b10000;
  localparam logic [NB-1:0] B_LR = 5'b01100;

  initial begin
    logic [NB-1:0] lvl;
    int            hold[NB];
    logic          lk;
    int            rst_left;

    reset           = 1'b1;
    btn_raw         = '0;
    difficulty_lock = 1'b0;
    model_reset();

    // Reset held, then released with all buttons idle
    for (int k = 0; k < 3; k++) drive('0, 1'b0, 1'b1);
    run('0, 1'b0, 4);
    chk("idle_diff", difficulty, 32'd1);

    // C held long: one press, difficulty 1 -> 2, nothing more while held
    run(B_C, 1'b0, 60);
    chk("c_hold_diff", difficulty, 32'd2);
    run('0, 1'b0, 10);

    // L glitches shorter than the debounce window never register
    run(B_L, 1'b0, 3);
    run('0,  1'b0, 1);
    run(B_L, 1'b0, 3);
    run('0,  1'b0, 10);
    chk("glitch_diff", difficulty, 32'd2);

    // L and R together: L wins; re-selecting L gives no change pulse
    run(B_LR, 1'b0, 10);
    run('0,   1'b0, 10);
    chk("lr_diff", difficulty, 32'd1);
    run(B_L, 1'b0, 10);
    run('0,  1'b0, 10);

    // Locked R press is discarded, not replayed once unlocked
    run(B_R, 1'b1, 10);
    run('0,  1'b1, 10);
    run('0,  1'b0, 5);
    chk("lock_diff", difficulty, 32'd1);
    run(B_R, 1'b0, 10);
    run('0,  1'b0, 10);
    chk("unlock_r_diff", difficulty, 32'd3);

    // Reset two cycles into a C debounce, C still held after release
    run(B_C, 1'b0, 4);
    drive(B_C, 1'b0, 1'b1);
    drive(B_C, 1'b0, 1'b1);
    run(B_C, 1'b0, 12);
    chk("rst_mid_diff", difficulty, 32'd2);
    run('0, 1'b0, 10);

    // Randomized buttons with mixed hold lengths, lock toggles and resets
    lvl      = '0;
    lk       = 1'b0;
    rst_left = 0;
    for (int i = 0; i < NB; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = ~lvl[i];
          hold[i] = int'($urandom_range(1, 9));
        end
        hold[i]--;
      end
      if ($urandom_range(0, 99) == 0) lk = ~lk;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = 3;
      drive(lvl, lk, rst_left > 0);
    end
    run('0, 1'b0, 2);

    @(posedge clock);
    #2;
    running = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain cyc=%0d got=%0d exp=0", cyc, sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire
